// File: rtl/i2c_master_ctl.sv
// i2c_master_ctl: single-master I2C register-access controller.
// Define I2C_MASTER_ACK_CHECK_EN to abort a frame on a NACK.
module i2c_master_ctl #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_adr,
  input  logic [7:0] reg_adr,
  input  logic [7:0] wr_dat,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_dat,
  output logic       SCL,
  inout  wire        SDA,
  output logic       SDA_MASTER
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic          rw_q, rw_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    wr_q, wr_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    rd_q, rd_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          scl_q, scl_d;
  logic          sdo_q, sdo_d;
  logic [1:0]    sync_q;
  logic          tick, smp, rd_byte, rd_nxt;
  logic [7:0]    txb;
`ifdef I2C_MASTER_ACK_CHECK_EN
  logic          nack;
`endif

  assign tick    = (state_q != S_IDLE) && (div_q == DIV_MAX);
  assign smp     = tick && (state_q == S_XFER) && (qtr_q == 2'd2);
  assign rd_byte = rw_q && (byte_q == 2'd2);
`ifdef I2C_MASTER_ACK_CHECK_EN
  assign nack    = smp && bit_q[3] && sync_q[1] && !rd_byte;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wr_d    = wr_q;
    sh_d    = sh_q;
    rd_d    = rd_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (state_q != S_IDLE) div_d = tick ? '0 : div_q + 1'b1;
    if (tick) qtr_d = qtr_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          div_d   = '0;
          qtr_d   = '0;
          rw_d    = rw;
          dev_d   = dev_adr;
          reg_d   = reg_adr;
          wr_d    = wr_dat;
          err_d   = 1'b0;
        end
      end
      S_START: begin
        if (tick && qtr_q == 2'd3) begin
          state_d = S_XFER;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      S_XFER: begin
        if (smp && !bit_q[3] && rd_byte) sh_d = {sh_q[6:0], sync_q[1]};
`ifdef I2C_MASTER_ACK_CHECK_EN
        if (nack) err_d = 1'b1;
`endif
        if (tick && qtr_q == 2'd3) begin
          bit_d = bit_q + 1'b1;
          if (bit_q[3]) begin
            bit_d  = '0;
            byte_d = byte_q + 1'b1;
            // a flagged NACK skips the remaining bytes
            if (err_q || byte_q == 2'd2) begin
              state_d = S_STOP;
              byte_d  = '0;
            end
          end
        end
      end
      S_STOP: begin
        if (tick && qtr_q == 2'd3) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (rw_q && !err_q) rd_d = sh_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // line levels follow the next state so they align with the quarters
  always_comb begin
    scl_d  = 1'b1;
    sdo_d  = 1'b1;
    rd_nxt = rw_d && (byte_d == 2'd2);
    unique case (1'b1)
      byte_d == 2'd0: txb = {dev_d, rw_d};
      byte_d == 2'd1: txb = reg_d;
      default:        txb = wr_d;
    endcase
    unique case (state_d)
      S_START: begin
        scl_d = (qtr_d != 2'd3);
        sdo_d = !qtr_d[1];
      end
      S_XFER: begin
        scl_d = qtr_d[1];
        sdo_d = (bit_d[3] || rd_nxt) ? 1'b1 : txb[~bit_d[2:0]];
      end
      S_STOP: begin
        scl_d = (qtr_d != 2'd0);
        sdo_d = qtr_d[1];
      end
      default: begin
        scl_d = 1'b1;
        sdo_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      rw_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wr_q    <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      scl_q   <= 1'b1;
      sdo_q   <= 1'b1;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wr_q    <= wr_d;
      sh_q    <= sh_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      done_q  <= done_d;
      scl_q   <= scl_d;
      sdo_q   <= sdo_d;
      sync_q  <= {sync_q[0], SDA};
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign ack_err    = err_q;
  assign rd_dat     = rd_q;
  assign SCL        = scl_q;
  assign SDA_MASTER = sdo_q;
  assign SDA        = sdo_q ? 1'bz : 1'b0;
endmodule

// File: tb/tb_i2c_master_ctl.sv
// Testbench for i2c_master_ctl: directed vector table plus
// busy-ignore and mid-frame reset sequences.
module tb_i2c_master_ctl;
  localparam int DIV  = 4;
  localparam int FULL = 1 + 116 * DIV;
  localparam int ABRT = 1 + 44 * DIV;
`ifdef I2C_MASTER_ACK_CHECK_EN
  localparam bit ACKCHK = 1'b1;
`else
  localparam bit ACKCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, rw;
  logic [6:0] dev_adr;
  logic [7:0] reg_adr, wr_dat;
  logic       busy, done, ack_err, SCL, SDA_MASTER;
  logic [7:0] rd_dat;
  wire        sda;
  logic       slv_low;
  logic       slv_en;
  logic [7:0] slv_val;

  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_master_ctl #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw),
    .dev_adr(dev_adr), .reg_adr(reg_adr), .wr_dat(wr_dat),
    .busy(busy), .done(done), .ack_err(ack_err), .rd_dat(rd_dat),
    .SCL(SCL), .SDA(sda), .SDA_MASTER(SDA_MASTER)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // bus monitor and slave model
  int n_start, n_stop, n_done, n_both, m_cnt, m_byte;
  logic [8:0] m_sh;
  logic [8:0] frm [0:3];
  logic scl_p, sda_p, rdm;

  initial begin
    slv_low = 1'b0;
    scl_p = 1'b1; sda_p = 1'b1;
    n_start = 0; n_stop = 0; n_done = 0; n_both = 0;
    m_cnt = 0; m_byte = 0; m_sh = '0;
    for (int k = 0; k < 4; k++) frm[k] = '1;
    forever begin
      @(negedge clk);
      if (scl_p && SCL && sda_p && !sda) begin
        n_start++; m_cnt = 0; m_byte = 0;
        for (int k = 0; k < 4; k++) frm[k] = '1;
      end
      if (scl_p && SCL && !sda_p && sda) n_stop++;
      if (!scl_p && SCL) begin
        m_sh = {m_sh[7:0], sda};
        m_cnt++;
        if (m_cnt == 9) begin
          if (m_byte < 4) frm[m_byte] = m_sh;
          m_byte++;
          m_cnt = 0;
        end
      end
      if (scl_p && !SCL) begin
        slv_low = 1'b0;
        rdm = frm[0][1];
        if (slv_en && m_byte < 3) begin
          if (m_byte == 2 && rdm) begin
            if (m_cnt < 8) slv_low = !slv_val[7 - m_cnt];
          end else if (m_cnt == 8) slv_low = 1'b1;
        end
      end
      if (done) n_done++;
      if (done && busy) n_both++;
      scl_p = SCL;
      sda_p = sda;
    end
  end

  task automatic run_txn(input logic r, input logic [6:0] d,
                         input logic [7:0] ra, input logic [7:0] wd,
                         input int glitch, output int lat,
                         output bit to);
    int t0;
    @(negedge clk);
    rw = r; dev_adr = d; reg_adr = ra; wr_dat = wd;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = (i == glitch);
      if (i == glitch) begin
        rw = ~r; dev_adr = ~d; reg_adr = ~ra; wr_dat = ~wd;
      end
      if (done) begin
        lat = cyc - t0;
        to = 1'b0;
        break;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] ra, wd, sv;
    logic       sk;
    int         nb, lat;
    logic       err;
    logic [7:0] rd, b0, b1, b2;
    logic       a0, a2;
  } vec_t;

  function automatic vec_t mk(logic r, logic [6:0] d, logic [7:0] ra,
                              logic [7:0] wd, logic [7:0] sv, logic sk,
                              int nb, int lat, logic er, logic [7:0] rd,
                              logic [7:0] b0, logic [7:0] b1,
                              logic [7:0] b2, logic a0, logic a2);
    vec_t v;
    v.rw = r; v.dev = d; v.ra = ra; v.wd = wd; v.sv = sv; v.sk = sk;
    v.nb = nb; v.lat = lat; v.err = er; v.rd = rd;
    v.b0 = b0; v.b1 = b1; v.b2 = b2; v.a0 = a0; v.a2 = a2;
    return v;
  endfunction

  vec_t tv [0:5];

  task automatic check_frame(input string nm, input vec_t v,
                             input int lat, input bit to,
                             input int s0, input int p0, input int d0);
    chk({nm, " timeout"}, 32'(to), 0);
    chk({nm, " latency"}, lat, v.lat);
    chk({nm, " ack_err"}, 32'(ack_err), 32'(v.err));
    chk({nm, " rd_dat"}, 32'(rd_dat), 32'(v.rd));
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " starts"}, n_start - s0, 1);
    chk({nm, " stops"}, n_stop - p0, 1);
    chk({nm, " dones"}, n_done - d0, 1);
    chk({nm, " bytes"}, m_byte, v.nb);
    chk({nm, " byte0"}, 32'(frm[0][8:1]), 32'(v.b0));
    chk({nm, " ack0"}, 32'(frm[0][0]), 32'(v.a0));
    if (v.nb > 1) chk({nm, " byte1"}, 32'(frm[1][8:1]), 32'(v.b1));
    if (v.nb > 2) begin
      chk({nm, " byte2"}, 32'(frm[2][8:1]), 32'(v.b2));
      chk({nm, " ack2"}, 32'(frm[2][0]), 32'(v.a2));
    end
  endtask

  initial begin
    int lat, s0, p0, d0;
    bit to;
    vec_t v;
    rst_n = 1'b0; start = 1'b0; rw = 1'b0;
    dev_adr = '0; reg_adr = '0; wr_dat = '0;
    slv_en = 1'b1; slv_val = '0;
    repeat (3) @(negedge clk);
    chk("reset SCL", 32'(SCL), 1);
    chk("reset SDA_MASTER", 32'(SDA_MASTER), 1);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset ack_err", 32'(ack_err), 0);
    chk("reset rd_dat", 32'(rd_dat), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    tv[0] = mk(0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, 3, FULL, 0, 8'h00,
               8'hA0, 8'h10, 8'hA5, 0, 0);
    tv[1] = mk(1, 7'h50, 8'h10, 8'h00, 8'h3C, 1, 3, FULL, 0, 8'h3C,
               8'hA1, 8'h10, 8'h3C, 0, 1);
    tv[2] = mk(0, 7'h2A, 8'h33, 8'h5A, 8'h00, 0,
               ACKCHK ? 1 : 3, ACKCHK ? ABRT : FULL, ACKCHK, 8'h3C,
               8'h54, 8'h33, 8'h5A, 1, 1);
    tv[3] = mk(1, 7'h2A, 8'h01, 8'h00, 8'h00, 0,
               ACKCHK ? 1 : 3, ACKCHK ? ABRT : FULL, ACKCHK,
               ACKCHK ? 8'h3C : 8'hFF, 8'h55, 8'h01, 8'hFF, 1, 1);
    tv[4] = mk(1, 7'h68, 8'hF0, 8'h00, 8'h81, 1, 3, FULL, 0, 8'h81,
               8'hD1, 8'hF0, 8'h81, 0, 1);
    tv[5] = mk(0, 7'h7F, 8'h00, 8'hFF, 8'h00, 1, 3, FULL, 0, 8'h81,
               8'hFE, 8'h00, 8'hFF, 0, 0);

    for (int i = 0; i < 6; i++) begin
      slv_en = tv[i].sk;
      slv_val = tv[i].sv;
      s0 = n_start; p0 = n_stop; d0 = n_done;
      run_txn(tv[i].rw, tv[i].dev, tv[i].ra, tv[i].wd, -1, lat, to);
      check_frame($sformatf("v%0d", i), tv[i], lat, to, s0, p0, d0);
    end

    // start while busy must not disturb the running frame
    slv_en = 1'b1;
    s0 = n_start; p0 = n_stop; d0 = n_done;
    run_txn(0, 7'h50, 8'h10, 8'hA5, 60, lat, to);
    repeat (20) @(negedge clk);
    v = mk(0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, 3, FULL, 0, 8'h81,
           8'hA0, 8'h10, 8'hA5, 0, 0);
    check_frame("busy_ignore", v, lat, to, s0, p0, d0);
    chk("busy_ignore idle", 32'(busy), 0);

    // reset during byte 1, bit 4
    d0 = n_done;
    @(negedge clk);
    rw = 1'b0; dev_adr = 7'h50; reg_adr = 8'h10; wr_dat = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_byte == 1 && m_cnt == 4 && !SCL) begin
        to = 1'b0;
        break;
      end
    end
    chk("midrst wait timeout", 32'(to), 0);
    chk("midrst pre SCL", 32'(SCL), 0);
    chk("midrst pre SDA_MASTER", 32'(SDA_MASTER), 0);
    chk("midrst pre busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst SCL", 32'(SCL), 1);
    chk("midrst SDA_MASTER", 32'(SDA_MASTER), 1);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    repeat (8) @(negedge clk);
    chk("midrst no done", n_done - d0, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst no late done", n_done - d0, 0);
    s0 = n_start; p0 = n_stop; d0 = n_done;
    run_txn(0, 7'h50, 8'h10, 8'hA5, -1, lat, to);
    v = mk(0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, 3, FULL, 0, 8'h00,
           8'hA0, 8'h10, 8'hA5, 0, 0);
    check_frame("after_rst", v, lat, to, s0, p0, d0);

    chk("busy_done overlap", n_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
